// File: rtl/idma_nd_req_arbiter.sv
// idma_nd_req_arbiter: round-robin sharing of one ND midend between NumReq requesters, with in-order response routing.
// Optional IDMA_ND_ARB_PRIO_EN adds prio_i, which gives a priority class to the arbitration.
module idma_nd_req_arbiter #(
   parameter int  NumReq         = 2,
   parameter int  MaxOutstanding = 4,
   parameter type idma_nd_req_t  = logic,
   parameter type idma_rsp_t     = logic,
   localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1,
   localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
   localparam int CntW = $clog2(MaxOutstanding + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  idma_nd_req_t [NumReq-1:0]       req_i,
   input  logic [NumReq-1:0]               req_valid_i,
   output logic [NumReq-1:0]               req_ready_o,
   output idma_rsp_t [NumReq-1:0]          rsp_o,
   output logic [NumReq-1:0]               rsp_valid_o,
   input  logic [NumReq-1:0]               rsp_ready_i,
`ifdef IDMA_ND_ARB_PRIO_EN
   input  logic [NumReq-1:0]               prio_i,
`endif
   output idma_nd_req_t                    nd_req_o,
   output logic                            nd_req_valid_o,
   input  logic                            nd_req_ready_i,
   input  idma_rsp_t                       nd_rsp_i,
   input  logic                            nd_rsp_valid_i,
   output logic                            nd_rsp_ready_o,
   output logic [CntW-1:0]                 outstanding_o,
   output logic                            busy_o
);
   localparam logic IDLE   = 1'b0;
   localparam logic LOCKED = 1'b1;

   logic                state_q;
   logic [IdW-1:0]      grant_q, rr_q, pick, sel, idx, head;
   logic [NumReq-1:0]   cand;
   logic [IdW-1:0]      ids_q [MaxOutstanding];
   logic [PtrW-1:0]     wr_q, rd_q;
   logic [CntW-1:0]     cnt_q;
   logic                full, empty, push, pop;

   always_comb begin
      cand = req_valid_i;
`ifdef IDMA_ND_ARB_PRIO_EN
      if (|(req_valid_i & prio_i)) cand = req_valid_i & prio_i;
`endif
      pick = rr_q;
      idx  = rr_q;
      // descending offsets so the nearest valid index at/after the pointer wins last
      for (int i = NumReq - 1; i >= 0; i--) begin
         idx = IdW'((int'(rr_q) + i) % NumReq);
         if (cand[idx]) pick = idx;
      end
   end

   assign full           = cnt_q == CntW'(MaxOutstanding);
   assign empty          = cnt_q == '0;
   assign sel            = (state_q == LOCKED) ? grant_q : pick;
   assign nd_req_o       = req_i[sel];
   assign nd_req_valid_o = !full && ((state_q == LOCKED) ? req_valid_i[grant_q] : |cand);
   assign push           = nd_req_valid_o && nd_req_ready_i;
   assign req_ready_o    = push ? NumReq'(1) << sel : '0;

   assign head           = ids_q[rd_q];
   assign nd_rsp_ready_o = !empty && rsp_ready_i[head];
   assign rsp_valid_o    = (nd_rsp_valid_i && !empty) ? NumReq'(1) << head : '0;
   assign pop            = nd_rsp_valid_i && nd_rsp_ready_o;
   assign outstanding_o  = cnt_q;
   assign busy_o         = nd_req_valid_o || !empty;

   always_comb for (int i = 0; i < NumReq; i++) rsp_o[i] = nd_rsp_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         if (push) begin
            state_q <= IDLE;
            rr_q    <= (sel == IdW'(NumReq - 1)) ? '0 : sel + 1'b1;
            wr_q    <= (wr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_q + 1'b1;
         end else if (state_q == IDLE && nd_req_valid_o) begin
            state_q <= LOCKED;
            grant_q <= pick;
         end
         if (pop) rd_q <= (rd_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_q + 1'b1;
         cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_i) if (push) ids_q[wr_q] <= sel;

   a_locked_valid : assert property (@(posedge clk_i) disable iff (rst_i)
      state_q == LOCKED |-> req_valid_i[grant_q]);
   a_rsp_no_id : assert property (@(posedge clk_i) disable iff (rst_i)
      !(nd_rsp_valid_i && empty));
endmodule

// File: tb/tb_idma_nd_req_arbiter.sv
// tb_idma_nd_req_arbiter: directed checks of arbitration, locking, ID FIFO back-pressure and response routing.
module tb_idma_nd_req_arbiter;
   logic             clk = 0, rst = 1;
   logic [3:0][7:0]  req, rsp;
   logic [3:0]       req_valid = 0, req_ready, rsp_valid, rsp_ready = 4'hf, prio = 0;
   logic [7:0]       nd_req, nd_rsp = 0;
   logic             nd_req_valid, nd_req_ready = 0, nd_rsp_valid = 0, nd_rsp_ready, busy;
   logic [1:0]       outstanding;
   int               checks = 0, errors = 0;

   idma_nd_req_arbiter #(
      .NumReq(4), .MaxOutstanding(2),
      .idma_nd_req_t(logic [7:0]), .idma_rsp_t(logic [7:0])
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .rsp_o(rsp), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
`ifdef IDMA_ND_ARB_PRIO_EN
      .prio_i(prio),
`endif
      .nd_req_o(nd_req), .nd_req_valid_o(nd_req_valid), .nd_req_ready_i(nd_req_ready),
      .nd_rsp_i(nd_rsp), .nd_rsp_valid_i(nd_rsp_valid), .nd_rsp_ready_o(nd_rsp_ready),
      .outstanding_o(outstanding), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 4; k++) req[k] = 8'hA0 + 8'(k);
      tick();
      tick();
      chk("rst_outstanding", 32'(outstanding), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_nd_valid", 32'(nd_req_valid), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      rst = 0;
      // round robin between 0 and 1, responses keep the FIFO at one entry
      req_valid = 4'b0011; nd_req_ready = 1;
      #1 chk("rr_a_req", 32'(nd_req), 32'hA0);
      chk("rr_a_ready", 32'(req_ready), 4'b0001);
      tick();
      nd_rsp_valid = 1; nd_rsp = 8'h01;
      #1 chk("rr_b_req", 32'(nd_req), 32'hA1);
      chk("rr_b_ready", 32'(req_ready), 4'b0010);
      chk("rr_b_rsp", 32'(rsp_valid), 4'b0001);
      chk("rr_b_ndrdy", 32'(nd_rsp_ready), 1);
      tick();
      chk("rr_c_req", 32'(nd_req), 32'hA0);
      chk("rr_c_rsp", 32'(rsp_valid), 4'b0010);
      tick();
      chk("rr_d_req", 32'(nd_req), 32'hA1);
      chk("rr_d_outst", 32'(outstanding), 1);
      tick();
      req_valid = 0;
      #1 chk("rr_e_rsp", 32'(rsp_valid), 4'b0010);
      chk("rr_e_ndvalid", 32'(nd_req_valid), 0);
      tick();
      nd_rsp_valid = 0;
      #1 chk("rr_idle_outst", 32'(outstanding), 0);
      chk("rr_idle_busy", 32'(busy), 0);
      // lock on req0 while the midend stalls; req1 arrives mid-transfer
      req_valid = 4'b0001; nd_req_ready = 0;
      #1 chk("lk_c0_req", 32'(nd_req), 32'hA0);
      chk("lk_c0_ready", 32'(req_ready), 0);
      tick();
      tick();
      req_valid = 4'b0011;
      #1 chk("lk_c2_req", 32'(nd_req), 32'hA0);
      chk("lk_c2_valid", 32'(nd_req_valid), 1);
      tick();
      tick();
      tick();
      nd_req_ready = 1;
      #1 chk("lk_c5_req", 32'(nd_req), 32'hA0);
      chk("lk_c5_ready", 32'(req_ready), 4'b0001);
      tick();
      req_valid = 4'b0010;
      #1 chk("lk_c6_req", 32'(nd_req), 32'hA1);
      chk("lk_c6_ready", 32'(req_ready), 4'b0010);
      tick();
      // FIFO full holds req2 off; a pop frees it only from the next cycle
      req_valid = 4'b0100;
      #1 chk("full_outst", 32'(outstanding), 2);
      chk("full_ndvalid", 32'(nd_req_valid), 0);
      chk("full_ready", 32'(req_ready), 0);
      chk("full_busy", 32'(busy), 1);
      tick();
      nd_rsp_valid = 1; nd_rsp = 8'h02;
      #1 chk("full_pop_ndvalid", 32'(nd_req_valid), 0);
      chk("full_pop_rsp", 32'(rsp_valid), 4'b0001);
      tick();
      nd_rsp_valid = 0;
      #1 chk("full_after_req", 32'(nd_req), 32'hA2);
      chk("full_after_ready", 32'(req_ready), 4'b0100);
      tick();
      req_valid = 0; nd_rsp_valid = 1; nd_rsp = 8'h03;
      #1 chk("drain_rsp1", 32'(rsp_valid), 4'b0010);
      tick();
      chk("drain_rsp2", 32'(rsp_valid), 4'b0100);
      tick();
      nd_rsp_valid = 0;
      #1 chk("drain_outst", 32'(outstanding), 0);
      // order 1,0,1 with requester 0 back-pressuring its response
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0001;
      tick();
      req_valid = 0; nd_rsp_valid = 1; nd_rsp = 8'h04; rsp_ready = 4'b1110;
      #1 chk("ord_rsp1", 32'(rsp_valid), 4'b0010);
      chk("ord_ndrdy1", 32'(nd_rsp_ready), 1);
      tick();
      req_valid = 4'b0010;
      #1 chk("ord_rsp2", 32'(rsp_valid), 4'b0001);
      chk("ord_hold_ndrdy", 32'(nd_rsp_ready), 0);
      chk("ord_push_ready", 32'(req_ready), 4'b0010);
      tick();
      req_valid = 0;
      #1 chk("ord_hold_rsp", 32'(rsp_valid), 4'b0001);
      chk("ord_hold_outst", 32'(outstanding), 2);
      tick();
      rsp_ready = 4'hf;
      #1 chk("ord_release", 32'(nd_rsp_ready), 1);
      tick();
      chk("ord_rsp3", 32'(rsp_valid), 4'b0010);
      tick();
      nd_rsp_valid = 0;
      #1 chk("ord_outst", 32'(outstanding), 0);
      // error response routed to requester 2
      req_valid = 4'b0100;
      #1 chk("err_req", 32'(nd_req), 32'hA2);
      tick();
      req_valid = 0; nd_rsp_valid = 1; nd_rsp = 8'hC0;
      #1 chk("err_rsp_valid", 32'(rsp_valid), 4'b0100);
      chk("err_rsp_data", 32'(rsp[2]), 32'hC0);
      tick();
      nd_rsp_valid = 0;
      // reset while locked drops lock and pointer
      req_valid = 4'b0001; nd_req_ready = 0;
      tick();
      rst = 1; req_valid = 0;
      tick();
      rst = 0;
      #1 chk("mrst_outst", 32'(outstanding), 0);
      chk("mrst_ndvalid", 32'(nd_req_valid), 0);
      req_valid = 4'b0011; nd_req_ready = 1;
      #1 chk("mrst_req", 32'(nd_req), 32'hA0);
      tick();
`ifdef IDMA_ND_ARB_PRIO_EN
      req_valid = 4'b1111; prio = 4'b0100; nd_rsp_valid = 1; nd_rsp = 8'h05;
      #1 chk("prio_first", 32'(nd_req), 32'hA2);
      tick();
      req_valid = 4'b1011; prio = 0;
      #1 chk("prio_rr3", 32'(nd_req), 32'hA3);
      tick();
      chk("prio_rr0", 32'(nd_req), 32'hA0);
      tick();
      chk("prio_rr1", 32'(nd_req), 32'hA1);
      tick();
`endif
      req_valid = 0; nd_rsp_valid = 1;
      tick();
      nd_rsp_valid = 0;
      #1 chk("end_outst", 32'(outstanding), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
